// File: rtl/spi_device_sync.sv
// SPI device front end: spi_clk/spi_cs/spi_mosi oversampled in the clk domain, all CPOL/CPHA modes.
// Optional macro SPI_DEVICE_SYNC_RX_HOLD_EN: rx_valid held until rx_ready, with sticky rx_overrun.
module spi_device_sync #(
    parameter int unsigned      WIDTH       = 8,
    parameter bit               CPOL        = 1'b0,
    parameter bit               CPHA        = 1'b0,
    parameter bit               MSB_FIRST   = 1'b1,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IDLE_TX     = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             spi_clk,
    input  logic             spi_cs,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    input  logic             rx_ready,
    output logic             rx_overrun,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ack,
    output logic             tx_underrun,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    state_e           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic             miso_q, miso_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    logic             sclk_s, cs_s, mosi_s;
    logic             sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic             word_done, cs_fall;
    logic [WIDTH-1:0] load_word;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_prev_d = sclk_s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= CPOL;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_edge   = sclk_s ^ sclk_prev_q;
    assign lead_edge   = sclk_edge && (sclk_s != CPOL);
    assign trail_edge  = sclk_edge && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    // The word boundary is a LOAD cycle too, so rx_valid and tx_ack/tx_underrun line up.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        miso_d    = miso_q;
        rx_data_d = rx_data_q;
        word_done = 1'b0;
        cs_fall   = 1'b0;
        load_word = tx_valid ? tx_data : IDLE_TX;
        case (state_q)
            ST_IDLE: begin
                miso_d    = 1'b1;
                bit_cnt_d = '0;
                rx_sr_d   = '0;
                if (!cs_s) begin
                    state_d = ST_LOAD;
                    cs_fall = 1'b1;
                end
            end
            ST_LOAD: begin
                bit_cnt_d = '0;
                if (!CPHA) begin
                    miso_d  = head_bit(load_word);
                    tx_sr_d = advance(load_word);
                end else begin
                    tx_sr_d = load_word;
                end
                state_d = cs_s ? ST_IDLE : ST_XFER;
            end
            ST_XFER: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                end else if (sample_edge) begin
                    rx_sr_d = MSB_FIRST ? {rx_sr_q[WIDTH-2:0], mosi_s}
                                        : {mosi_s, rx_sr_q[WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        rx_data_d = rx_sr_d;
                        word_done = 1'b1;
                        state_d   = ST_LOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_edge && (CPHA || (bit_cnt_q != '0))) begin
                    // CPHA=0: count 0 here means the next word's first bit is already out.
                    miso_d  = head_bit(tx_sr_q);
                    tx_sr_d = advance(tx_sr_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            miso_q    <= 1'b1;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            miso_q    <= miso_d;
            rx_data_q <= rx_data_d;
        end
    end

`ifdef SPI_DEVICE_SYNC_RX_HOLD_EN
    logic rx_overrun_q, rx_overrun_d;

    always_comb begin
        rx_valid_d   = rx_valid_q & ~rx_ready;
        rx_overrun_d = rx_overrun_q;
        if (cs_fall) begin
            rx_overrun_d = 1'b0;
        end
        if (word_done) begin
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ready) begin
                rx_overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign rx_overrun = rx_overrun_q;
`else
    logic unused_rx_ready;

    always_comb begin
        rx_valid_d = word_done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid_d;
        end
    end

    assign unused_rx_ready = rx_ready;
    assign rx_overrun      = 1'b0;
`endif

    assign spi_miso    = miso_q;
    assign spi_miso_oe = (state_q != ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign tx_ack      = (state_q == ST_LOAD) && tx_valid;
    assign tx_underrun = (state_q == ST_LOAD) && !tx_valid;

endmodule

// File: tb/tb_spi_device_sync.sv
// Bench for spi_device_sync: four instances (mode 0, mode 3, mode 1, 16-bit LSB-first) against a slot-level model.
module tb_spi_device_sync;

    typedef logic [31:0] wq_t[$];

    localparam int H = 83;

    logic        clk;
    logic        reset_n;
    logic        rx_ready;
    logic        sclk[4];
    logic        cs_n[4];
    logic        mosi[4];
    logic        txv[4];
    logic [31:0] txd[4];
    logic        miso[4];
    logic        oe[4];
    logic        rxv[4];
    logic        txack[4];
    logic        txund[4];
    logic        ovr[4];
    logic        busy[4];
    logic [7:0]  rxd0, rxd1, rxd2;
    logic [15:0] rxd3;

    int          total = 0;
    int          passed = 0;
    int          act = 0;
    wq_t         tx_q;
    wq_t         rx_got;
    bit          miso_got[$];
    int          ack_cnt = 0;
    int          und_cnt = 0;
    int          coin_cnt = 0;

    spi_device_sync #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_m0 (
        .clk(clk), .reset_n(reset_n), .spi_clk(sclk[0]), .spi_cs(cs_n[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .spi_miso_oe(oe[0]), .rx_valid(rxv[0]), .rx_data(rxd0),
        .rx_ready(rx_ready), .rx_overrun(ovr[0]), .tx_valid(txv[0]), .tx_data(txd[0][7:0]),
        .tx_ack(txack[0]), .tx_underrun(txund[0]), .busy(busy[0]));

    spi_device_sync #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_m3 (
        .clk(clk), .reset_n(reset_n), .spi_clk(sclk[1]), .spi_cs(cs_n[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .spi_miso_oe(oe[1]), .rx_valid(rxv[1]), .rx_data(rxd1),
        .rx_ready(rx_ready), .rx_overrun(ovr[1]), .tx_valid(txv[1]), .tx_data(txd[1][7:0]),
        .tx_ack(txack[1]), .tx_underrun(txund[1]), .busy(busy[1]));

    spi_device_sync #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_m1 (
        .clk(clk), .reset_n(reset_n), .spi_clk(sclk[2]), .spi_cs(cs_n[2]), .spi_mosi(mosi[2]),
        .spi_miso(miso[2]), .spi_miso_oe(oe[2]), .rx_valid(rxv[2]), .rx_data(rxd2),
        .rx_ready(rx_ready), .rx_overrun(ovr[2]), .tx_valid(txv[2]), .tx_data(txd[2][7:0]),
        .tx_ack(txack[2]), .tx_underrun(txund[2]), .busy(busy[2]));

    spi_device_sync #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_w16 (
        .clk(clk), .reset_n(reset_n), .spi_clk(sclk[3]), .spi_cs(cs_n[3]), .spi_mosi(mosi[3]),
        .spi_miso(miso[3]), .spi_miso_oe(oe[3]), .rx_valid(rxv[3]), .rx_data(rxd3),
        .rx_ready(rx_ready), .rx_overrun(ovr[3]), .tx_valid(txv[3]), .tx_data(txd[3][15:0]),
        .tx_ack(txack[3]), .tx_underrun(txund[3]), .busy(busy[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int width_of(input int i);
        return (i == 3) ? 16 : 8;
    endfunction

    function automatic bit cpol_of(input int i);
        return (i == 1);
    endfunction

    function automatic bit cpha_of(input int i);
        return (i == 1) || (i == 2);
    endfunction

    function automatic bit msb_of(input int i);
        return (i != 3);
    endfunction

    function automatic logic [31:0] mask_of(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] rxd_of(input int i);
        case (i)
            0:       return {24'd0, rxd0};
            1:       return {24'd0, rxd1};
            2:       return {24'd0, rxd2};
            default: return {16'd0, rxd3};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_tx();
        for (int i = 0; i < 4; i++) begin
            txv[i] = (i == act) && (tx_q.size() > 0);
            txd[i] = (tx_q.size() > 0) ? tx_q[0] : 32'd0;
        end
    endtask

    task automatic check_reset(input string tag, input int i);
        chk($sformatf("%s/miso%0d", tag, i), {31'd0, miso[i]}, 32'd1);
        chk($sformatf("%s/oe%0d", tag, i), {31'd0, oe[i]}, 32'd0);
        chk($sformatf("%s/rxv%0d", tag, i), {31'd0, rxv[i]}, 32'd0);
        chk($sformatf("%s/rxd%0d", tag, i), rxd_of(i), 32'd0);
        chk($sformatf("%s/ack%0d", tag, i), {31'd0, txack[i]}, 32'd0);
        chk($sformatf("%s/und%0d", tag, i), {31'd0, txund[i]}, 32'd0);
        chk($sformatf("%s/ovr%0d", tag, i), {31'd0, ovr[i]}, 32'd0);
        chk($sformatf("%s/busy%0d", tag, i), {31'd0, busy[i]}, 32'd0);
    endtask

    // Master side: drives nbits of mw in the instance's bit order, samples MISO on its sample edge.
    task automatic spi_frame(input int i, input wq_t mw, input int nbits);
        int          w;
        bit          cp, ph, ms;
        bit          bits[$];
        logic [31:0] wd;
        w  = width_of(i);
        cp = cpol_of(i);
        ph = cpha_of(i);
        ms = msb_of(i);
        for (int k = 0; k < nbits; k++) begin
            wd = ((k / w) < mw.size()) ? mw[k / w] : 32'd0;
            bits.push_back(ms ? wd[w - 1 - (k % w)] : wd[k % w]);
        end
        cs_n[i] = 1'b0;
        #150;
        for (int k = 0; k < nbits; k++) begin
            if (!ph) begin
                mosi[i] = bits[k];
                #H;
                sclk[i] = ~cp;
                miso_got.push_back(miso[i]);
                #H;
                sclk[i] = cp;
            end else begin
                sclk[i] = ~cp;
                mosi[i] = bits[k];
                #H;
                sclk[i] = cp;
                miso_got.push_back(miso[i]);
                #H;
            end
            if (k == 0) begin
                chk($sformatf("busy_mid%0d", i), {31'd0, busy[i]}, 32'd1);
                chk($sformatf("oe_mid%0d", i), {31'd0, oe[i]}, 32'd1);
            end
        end
        #H;
        cs_n[i] = 1'b1;
        mosi[i] = 1'b0;
        #300;
    endtask

    // Model: one tx slot at frame start plus one per completed word; slots beyond the queue send all-ones.
    task automatic run_test(input string tag, input int i, input wq_t mw, input int nbits, input wq_t tw);
        int          w, done, slots, nack;
        logic [31:0] obs, exp, sw;
        int          pos;
        w = width_of(i);
        act = i;
        tx_q = tw;
        drive_tx();
        rx_got.delete();
        miso_got.delete();
        ack_cnt = 0;
        und_cnt = 0;
        coin_cnt = 0;
        #50;
        spi_frame(i, mw, nbits);
        done  = nbits / w;
        slots = done + 1;
        nack  = (slots < tw.size()) ? slots : tw.size();
        chk({tag, "/rx_count"}, rx_got.size(), done);
        for (int k = 0; k < done; k++) begin
            obs = (k < rx_got.size()) ? rx_got[k] : 32'hxxxx_xxxx;
            chk($sformatf("%s/rx_word%0d", tag, k), obs, mw[k] & mask_of(w));
        end
        chk({tag, "/tx_ack_count"}, ack_cnt, nack);
        chk({tag, "/tx_underrun_count"}, und_cnt, slots - nack);
        chk({tag, "/rx_tx_coincide"}, coin_cnt, done);
        for (int s = 0; s * w < nbits; s++) begin
            sw  = (s < tw.size()) ? (tw[s] & mask_of(w)) : mask_of(w);
            obs = '0;
            exp = '0;
            for (int k = 0; (k < w) && (s * w + k < nbits); k++) begin
                pos = msb_of(i) ? (w - 1 - k) : k;
                obs[pos] = (s * w + k < miso_got.size()) ? miso_got[s * w + k] : 1'bx;
                exp[pos] = sw[pos];
            end
            chk($sformatf("%s/miso_word%0d", tag, s), obs, exp);
        end
        chk({tag, "/oe_after"}, {31'd0, oe[i]}, 32'd0);
        chk({tag, "/busy_after"}, {31'd0, busy[i]}, 32'd0);
        chk({tag, "/miso_after"}, {31'd0, miso[i]}, 32'd1);
        tx_q.delete();
        drive_tx();
    endtask

    initial begin
        wq_t mw, tw;
        int  ii, nw, nb, w;
        reset_n  = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sclk[i] = cpol_of(i);
            cs_n[i] = 1'b1;
            mosi[i] = 1'b0;
            txv[i]  = 1'b0;
            txd[i]  = 32'd0;
        end
        #23;
        for (int i = 0; i < 4; i++) check_reset("reset", i);
        reset_n = 1'b1;

        fork
            forever begin
                bit pop;
                @(negedge clk);
                pop = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (rxv[i]) rx_got.push_back(rxd_of(i));
                    if (txack[i]) begin
                        ack_cnt++;
                        pop = 1'b1;
                    end
                    if (txund[i]) und_cnt++;
                    if (rxv[i] && (txack[i] || txund[i])) coin_cnt++;
                end
                if (pop) begin
                    @(posedge clk);
                    #1;
                    if (tx_q.size() > 0) void'(tx_q.pop_front());
                    drive_tx();
                end
            end
        join_none
        #100;

        mw = {32'h3C};             tw = {32'hA5};
        run_test("mode0", 0, mw, 8, tw);
        mw = {32'h12, 32'h34};     tw = {32'h55, 32'hAA};
        run_test("mode3", 1, mw, 16, tw);
        mw = {32'hC3};             tw = {};
        run_test("mode1_underrun", 2, mw, 8, tw);
        mw = {32'h1234};           tw = {32'h8001};
        run_test("w16_lsb", 3, mw, 16, tw);
        chk("w16_lsb/first_miso", {31'd0, miso_got[0]}, 32'd1);
        chk("w16_lsb/last_miso", {31'd0, miso_got[15]}, 32'd1);
        mw = {32'h5A};             tw = {32'h77};
        run_test("cs_abort", 0, mw, 5, tw);
        mw = {32'hC7};             tw = {32'hE1};
        run_test("after_abort", 0, mw, 8, tw);

        act = 0;
        tx_q = {32'h3C};
        drive_tx();
        cs_n[0] = 1'b0;
        #150;
        for (int k = 0; k < 3; k++) begin
            mosi[0] = (k % 2 == 1);
            #H;
            sclk[0] = 1'b1;
            #H;
            sclk[0] = 1'b0;
        end
        reset_n = 1'b0;
        #3;
        for (int i = 0; i < 4; i++) check_reset("mid_reset", i);
        #20;
        reset_n = 1'b1;
        #50;
        cs_n[0] = 1'b1;
        mosi[0] = 1'b0;
        #300;
        tx_q.delete();
        drive_tx();

        rx_ready = 1'b0;
        mw = {32'h11, 32'h22};
        spi_frame(0, mw, 16);
        chk("hold/rx_data", rxd_of(0), 32'h22);
`ifdef SPI_DEVICE_SYNC_RX_HOLD_EN
        chk("hold/rx_valid_held", {31'd0, rxv[0]}, 32'd1);
        chk("hold/overrun_set", {31'd0, ovr[0]}, 32'd1);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        #20;
        chk("hold/rx_valid_consumed", {31'd0, rxv[0]}, 32'd0);
        chk("hold/overrun_sticky", {31'd0, ovr[0]}, 32'd1);
        cs_n[0] = 1'b0;
        #150;
        chk("hold/overrun_cleared", {31'd0, ovr[0]}, 32'd0);
        cs_n[0] = 1'b1;
        #300;
`else
        chk("strobe/rx_valid_low", {31'd0, rxv[0]}, 32'd0);
        chk("strobe/overrun_tied", {31'd0, ovr[0]}, 32'd0);
`endif
        rx_ready = 1'b1;
        #50;

        for (int r = 0; r < 8; r++) begin
            ii = $urandom_range(0, 3);
            w  = width_of(ii);
            nw = $urandom_range(1, 3);
            mw = {};
            tw = {};
            for (int k = 0; k < nw; k++) mw.push_back($urandom() & mask_of(w));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tw.push_back($urandom() & mask_of(w));
            nb = nw * w;
            if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, nw * w - 1);
            run_test($sformatf("rand%0d_i%0d", r, ii), ii, mw, nb, tw);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
